// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-beat line refill, per-set
// round-robin replacement and whole-cache flush.
module icache_assoc #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int LINE_W = 128,
    parameter int BEAT_W = 32,
    parameter int SETS   = 16,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic [INST_W-1:0] instr_data,
    output logic              miss,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_beat_valid,
    input  logic [BEAT_W-1:0] mem_data
);

    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int BYTE_W = $clog2(INST_W / 8);
    localparam int WORDS  = LINE_W / INST_W;
    localparam int WRD_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, REFILL, FLUSH_PEND} state_t;

    state_t state, state_nx;

    logic [SETS-1:0][WAYS-1:0]  valid;
    logic [TAG_W-1:0]           tags  [SETS][WAYS];
    logic [LINE_W-1:0]          lines [SETS][WAYS];
    logic [SETS-1:0][WAY_W-1:0] rr_ptr;

    logic [CNT_W-1:0]  beat_cnt;
    logic              flush_pend;
    logic [ADDR_W-1:0] addr_buff;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] fill_line;

    logic [TAG_W-1:0] req_tag, buf_tag;
    logic [IDX_W-1:0] req_idx, buf_idx;
    logic [WRD_W-1:0] req_word;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;

    logic start_refill, take_beat, last_beat, clear_all;
    logic unused_bits;

    assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_word = req_addr[BYTE_W +: WRD_W];
    assign buf_tag  = addr_buff[ADDR_W-1 -: TAG_W];
    assign buf_idx  = addr_buff[OFF_W +: IDX_W];
    assign mem_addr = addr_buff;

    assign unused_bits = ^req_addr[BYTE_W-1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign instr_data = lines[req_idx][hit_way][req_word*INST_W +: INST_W];

    // Descending scan so the lowest-numbered invalid way wins over the pointer.
    always_comb begin
        victim = rr_ptr[buf_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[buf_idx][w]) begin
                victim = WAY_W'(w);
            end
        end
    end

    always_comb begin
        fill_line = line_buf;
        fill_line[beat_cnt*BEAT_W +: BEAT_W] = mem_data;
    end

    always_comb begin
        state_nx     = state;
        miss         = 1'b0;
        start_refill = 1'b0;
        take_beat    = 1'b0;
        last_beat    = 1'b0;
        clear_all    = 1'b0;
        case (state)
            IDLE: begin
                miss = req_valid & ~hit;
                if (flush) begin
                    clear_all = 1'b1;
                end else if (miss) begin
                    start_refill = 1'b1;
                    state_nx     = REFILL;
                end
            end
            REFILL: begin
                miss      = 1'b1;
                take_beat = mem_beat_valid;
                if (mem_beat_valid && beat_cnt == CNT_W'(BEATS - 1)) begin
                    last_beat = 1'b1;
                    state_nx  = (flush_pend || flush) ? FLUSH_PEND : IDLE;
                end
            end
            FLUSH_PEND: begin
                miss      = 1'b1;
                clear_all = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            flush_pend <= 1'b0;
            mem_req    <= 1'b0;
            addr_buff  <= '0;
        end else begin
            state   <= state_nx;
            mem_req <= (state_nx == REFILL);

            if (start_refill) begin
                addr_buff <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                beat_cnt  <= '0;
            end else if (take_beat) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end

            // A flush seen mid-refill is deferred until the line is installed.
            if (state == REFILL && flush) begin
                flush_pend <= 1'b1;
            end else if (state == FLUSH_PEND) begin
                flush_pend <= 1'b0;
            end

            if (clear_all) begin
                valid <= '0;
            end else if (last_beat) begin
                valid[buf_idx][victim] <= 1'b1;
                if (WAYS > 1) begin
                    rr_ptr[buf_idx] <= rr_ptr[buf_idx] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take_beat) begin
            line_buf[beat_cnt*BEAT_W +: BEAT_W] <= mem_data;
        end
        if (last_beat) begin
            tags[buf_idx][victim]  <= buf_tag;
            lines[buf_idx][victim] <= fill_line;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: default 2-way build plus a direct-mapped,
// 2-beat build.
module tb_icache_assoc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, flush, miss, mem_req, mem_beat_valid;
    logic [31:0] req_addr, instr_data, mem_addr, mem_data;

    logic        d_rst, d_req_valid, d_flush, d_miss, d_mem_req, d_beat_valid;
    logic [31:0] d_req_addr, d_instr, d_mem_addr, d_mem_data;

    int n_checks = 0;
    int n_errors = 0;

    icache_assoc u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .flush(flush), .instr_data(instr_data), .miss(miss), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_beat_valid(mem_beat_valid), .mem_data(mem_data)
    );

    icache_assoc #(.SETS(4), .WAYS(1), .LINE_W(64), .BEAT_W(32)) u_dm (
        .clk(clk), .rst(d_rst), .req_valid(d_req_valid), .req_addr(d_req_addr),
        .flush(d_flush), .instr_data(d_instr), .miss(d_miss), .mem_req(d_mem_req),
        .mem_addr(d_mem_addr), .mem_beat_valid(d_beat_valid), .mem_data(d_mem_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input string tg, input logic [31:0] addr, input logic [31:0] base);
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        check({tg, " miss"}, 32'(miss), 1);
        check({tg, " req idle"}, 32'(mem_req), 0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            mem_beat_valid = 1'b1;
            mem_data       = base + i;
            @(negedge clk);
            check({tg, " refill miss"}, 32'(miss), 1);
            check({tg, " mem_req"}, 32'(mem_req), 1);
            check({tg, " mem_addr"}, mem_addr, {addr[31:4], 4'h0});
            next_cycle();
        end
        mem_beat_valid = 1'b0;
        @(negedge clk);
        check({tg, " hit"}, 32'(miss), 0);
        check({tg, " data"}, instr_data, base + 32'(addr[3:2]));
        check({tg, " req off"}, 32'(mem_req), 0);
        req_valid = 1'b0;
        next_cycle();
    endtask

    task automatic probe(input string tg, input logic [31:0] addr, input logic exp_miss,
                         input logic [31:0] exp_data);
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        check({tg, " miss"}, 32'(miss), 32'(exp_miss));
        if (!exp_miss) check({tg, " data"}, instr_data, exp_data);
        req_valid = 1'b0;
        next_cycle();
    endtask

    task automatic dm_fill(input string tg, input logic [31:0] addr, input logic [31:0] base);
        d_req_valid = 1'b1;
        d_req_addr  = addr;
        @(negedge clk);
        check({tg, " miss"}, 32'(d_miss), 1);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            d_beat_valid = 1'b1;
            d_mem_data   = base + i;
            @(negedge clk);
            check({tg, " refill miss"}, 32'(d_miss), 1);
            check({tg, " mem_addr"}, d_mem_addr, {addr[31:3], 3'b000});
            next_cycle();
        end
        d_beat_valid = 1'b0;
        @(negedge clk);
        check({tg, " hit"}, 32'(d_miss), 0);
        check({tg, " data"}, d_instr, base + 32'(addr[2]));
        d_req_valid = 1'b0;
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [6:0] pat;
        int k;
        pat = 7'b1011001;

        rst = 1'b1; req_valid = 1'b1; req_addr = 32'h104; flush = 1'b0;
        mem_beat_valid = 1'b0; mem_data = '0;
        d_rst = 1'b1; d_req_valid = 1'b0; d_req_addr = '0; d_flush = 1'b0;
        d_beat_valid = 1'b0; d_mem_data = '0;
        next_cycle();
        @(negedge clk);
        check("reset mem_req", 32'(mem_req), 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset miss", 32'(miss), 1);
        req_valid = 1'b0;
        #1;
        check("reset miss idle", 32'(miss), 0);
        next_cycle();
        rst = 1'b0; d_rst = 1'b0;

        // Cold miss then a hit on another word of the same line.
        fill("cold", 32'h104, 32'hA0);
        probe("cold 10c", 32'h10C, 1'b0, 32'hA3);

        // Refill with gaps between beats.
        req_valid = 1'b1; req_addr = 32'h344;
        @(negedge clk);
        check("gap miss0", 32'(miss), 1);
        next_cycle();
        k = 0;
        for (int i = 0; i < 7; i++) begin
            mem_beat_valid = pat[i];
            mem_data       = 32'hB0 + k;
            if (pat[i]) k++;
            @(negedge clk);
            check("gap held miss", 32'(miss), 1);
            check("gap mem_req", 32'(mem_req), 1);
            next_cycle();
        end
        mem_beat_valid = 1'b0;
        @(negedge clk);
        check("gap hit", 32'(miss), 0);
        check("gap data", instr_data, 32'hB1);
        req_valid = 1'b0;
        next_cycle();
        probe("gap 34c", 32'h34C, 1'b0, 32'hB3);

        // Round-robin replacement in set 0 from a clean state.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        probe("post-rst 104", 32'h104, 1'b1, 32'h0);
        fill("r000", 32'h000, 32'h10);
        fill("r100", 32'h100, 32'h20);
        fill("r200", 32'h200, 32'h30);
        probe("keep 100", 32'h100, 1'b0, 32'h20);
        fill("r000b", 32'h000, 32'h40);
        probe("evict 100", 32'h100, 1'b1, 32'h0);
        probe("keep 200", 32'h200, 1'b0, 32'h30);

        // Flush in IDLE.
        req_valid = 1'b1; req_addr = 32'h200; flush = 1'b1;
        @(negedge clk);
        check("flush cycle hit", 32'(miss), 0);
        req_valid = 1'b0;
        next_cycle();
        flush = 1'b0;
        probe("flushed 200", 32'h200, 1'b1, 32'h0);
        probe("flushed 000", 32'h000, 1'b1, 32'h0);

        // Flush beats a simultaneous miss: no refill starts.
        req_valid = 1'b1; req_addr = 32'h500; flush = 1'b1;
        @(negedge clk);
        check("flush+miss miss", 32'(miss), 1);
        next_cycle();
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("flush+miss no req", 32'(mem_req), 0);
        next_cycle();

        // Flush during a refill.
        req_valid = 1'b1; req_addr = 32'h600;
        @(negedge clk);
        check("fr miss0", 32'(miss), 1);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            mem_beat_valid = 1'b1;
            mem_data       = 32'hC0 + i;
            flush          = (i == 1);
            @(negedge clk);
            check("fr refill miss", 32'(miss), 1);
            next_cycle();
        end
        flush = 1'b0; mem_beat_valid = 1'b0;
        @(negedge clk);
        check("fr pend miss", 32'(miss), 1);
        check("fr pend req", 32'(mem_req), 0);
        req_valid = 1'b0;
        next_cycle();
        probe("fr after", 32'h600, 1'b1, 32'h0);

        // Reset in the middle of a refill.
        req_valid = 1'b1; req_addr = 32'h704;
        @(negedge clk);
        check("rr miss0", 32'(miss), 1);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            mem_beat_valid = 1'b1;
            mem_data       = 32'hD0 + i;
            next_cycle();
        end
        mem_beat_valid = 1'b0; rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("rr pre req", 32'(mem_req), 1);
        next_cycle();
        rst = 1'b0; mem_beat_valid = 1'b1; mem_data = 32'hEE;
        @(negedge clk);
        check("rr post req", 32'(mem_req), 0);
        next_cycle();
        mem_beat_valid = 1'b0;
        fill("rr fresh", 32'h704, 32'hF0);

        // Direct-mapped, 2-beat build: conflicting lines evict each other.
        dm_fill("dm 004", 32'h004, 32'h50);
        dm_fill("dm 024", 32'h024, 32'h60);
        d_req_valid = 1'b1; d_req_addr = 32'h004;
        @(negedge clk);
        check("dm evicted 004", 32'(d_miss), 1);
        d_req_valid = 1'b0;
        next_cycle();
        d_req_valid = 1'b1; d_req_addr = 32'h020;
        @(negedge clk);
        check("dm keep 020 miss", 32'(d_miss), 0);
        check("dm keep 020 data", d_instr, 32'h60);
        d_req_valid = 1'b0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache for the fetch stage. It replaces the direct-mapped, single-transfer cache with configurable sets, ways and line size, and refills a line over a multi-beat memory channel. Victims are chosen per set by round-robin, and a whole-cache flush is supported. It sits between the fetch PC logic and the instruction memory port.

## Interface
- ADDR_W, 32, address width
- INST_W, 32, instruction width
- LINE_W, 128, line width in bits; must be a multiple of BEAT_W and of INST_W
- BEAT_W, 32, memory refill beat width
- SETS, 16, number of sets; power of two, ≥2
- WAYS, 2, associativity; power of two, ≥1
- Derived values:
  - OFF_W = log2(LINE_W/8)
  - IDX_W = log2(SETS)
  - TAG_W = ADDR_W − IDX_W − OFF_W
  - BEATS = LINE_W/BEAT_W

- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- req_valid  in  1  fetch request valid
- req_addr  in  ADDR_W  fetch byte address, INST_W-aligned
- flush  in  1  invalidate all lines (one-cycle pulse)
- instr_data  out  INST_W  selected instruction; valid when req_valid & ~miss
- miss  out  1  request not serviceable this cycle; requester must hold req_addr
- mem_req  out  1  refill request, registered
- mem_addr  out  ADDR_W  line-aligned refill address (low OFF_W bits zero)
- mem_beat_valid  in  1  refill beat present on mem_data
- mem_data  in  BEAT_W  refill beat, delivered in ascending address order

## Operation
- Address split:
  - tag = req_addr[ADDR_W−1 : IDX_W+OFF_W]
  - index = req_addr[IDX_W+OFF_W−1 : OFF_W]
  - word = req_addr[OFF_W−1 : log2(INST_W/8)]
- Lookup is combinational. A way hits when valid[set][w] and tag[set][w]==tag. At most one way may hit; instr_data is the hit way's line word `word`.
- FSM states: IDLE, REFILL, FLUSH_PEND.
- IDLE:
  - miss = req_valid & ~hit.
  - On a miss, latch the line-aligned req_addr into addr_buff, clear the beat counter, go to REFILL.
  - flush in IDLE clears every valid bit at the clock edge; the state stays IDLE. flush wins over a simultaneous miss: no refill starts, miss stays 1, and the lookup repeats next cycle.
- REFILL:
  - miss = 1, mem_req = 1, mem_addr = addr_buff.
  - On each mem_beat_valid, store mem_data into line-buffer slot beat_cnt, then increment beat_cnt. Gaps between beats are allowed.
  - When the last beat (beat_cnt == BEATS−1) arrives, write line buffer plus that beat, tag and valid=1 into the victim way of addr_buff's set. Advance that set's round-robin pointer. Return to IDLE.
- Victim selection: the lowest-numbered invalid way in the set; otherwise the way at the set's round-robin pointer, which wraps mod WAYS.
- flush during REFILL: latched in a pending bit. The refill completes and installs normally, then the FSM enters FLUSH_PEND for one cycle: all valid bits are cleared, miss=1, then IDLE.
- req_addr changes during REFILL are ignored. The refill always targets addr_buff.
- WAYS=1 degenerates to direct-mapped; the round-robin pointer is unused.

## Timing
- Reset values:
  - state IDLE; all valid=0; round-robin pointers 0; beat_cnt 0; pending flush 0
  - mem_req=0, mem_addr=0
  - miss = req_valid (every lookup misses); instr_data don't-care
- rst mid-refill: next cycle state is IDLE, mem_req=0 and all lines invalid. Beats arriving after reset are ignored.
- Hit latency: 0 cycles; data is valid in the same cycle as the request.
- Miss penalty:
  - Cycle 0: miss detected.
  - Cycle 1: mem_req=1.
  - Beats arrive at cycle ≥1. If the last beat arrives in cycle N, the line is written at the end of cycle N.
  - Cycle N+1: IDLE; the held request hits (miss=0).
- With back-to-back beats from cycle 1, N=BEATS, so the penalty is BEATS+1 cycles.
- mem_req deasserts in the cycle after the last beat. The memory must not send beats while mem_req=0.

## Test plan
- Cold miss (defaults): req_addr=0x104 → miss=1, mem_addr=0x100; beats 0xA0,0xA1,0xA2,0xA3 in cycles 1–4 → cycle 5 miss=0, instr_data=0xA1; 0x10C then hits with 0xA3.
- Beat gaps: same miss with mem_beat_valid toggling 1,0,0,1,1,0,1 → line installed only after the 4th beat; miss stays high until then; data correct.
- Replacement, SETS=16/WAYS=2: fill lines 0x000 and 0x100 (same set 0), then miss on 0x200 → evicts way 0 (0x000). 0x100 still hits; 0x000 misses again and evicts way 1 (0x100).
- Flush: with lines resident, pulse flush in IDLE → next cycle all prior addresses miss. Pulse flush during a refill → refill completes, one FLUSH_PEND cycle with miss=1, then the refilled address misses.
- Reset mid-refill: assert rst after beat 2 of 4 → next cycle mem_req=0, state IDLE. A later beat is ignored; a request to the same address misses and starts a fresh 4-beat refill.
- Parameter sweep: WAYS=1, SETS=4, LINE_W=64, BEAT_W=32 → 2-beat refill, 3-cycle penalty, conflicting lines evict each other.
